wb_arbiter: RTL

Two-master, one-slave Wishbone B4 classic arbiter. It shares the single system bus, which feeds the address decoder and slaves, between the instruction-fetch master (m0) and the load/store master (m1). Arbitration is round-robin; a grant is held for the whole bus cycle (CYC high). Slave responses are routed only to the granted master.

---
 rtl/wb_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone B4 classic arbiter, two masters (m0 fetch, m1 load/store) onto one slave bus.
// Latency: 1 cycle from CYC to grant; once granted, request and response paths are combinational.
// Backpressure: a grant is held for the whole CYC; the other master waits, and the slave stalls by withholding ACK/ERR.
// Build option: define WB_ARB_TIMEOUT_EN to force an ERR after TIMEOUT_CYCLES stalled strobe cycles.
module wb_arbiter #(
  parameter int ADR_WIDTH      = 32,
  parameter int DAT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,

  input  logic                   m0_cyc_i,
  input  logic                   m0_stb_i,
  input  logic                   m0_we_i,
  input  logic [ADR_WIDTH-1:0]   m0_adr_i,
  input  logic [DAT_WIDTH-1:0]   m0_dat_i,
  input  logic [DAT_WIDTH/8-1:0] m0_sel_i,
  output logic [DAT_WIDTH-1:0]   m0_dat_o,
  output logic                   m0_ack_o,
  output logic                   m0_err_o,

  input  logic                   m1_cyc_i,
  input  logic                   m1_stb_i,
  input  logic                   m1_we_i,
  input  logic [ADR_WIDTH-1:0]   m1_adr_i,
  input  logic [DAT_WIDTH-1:0]   m1_dat_i,
  input  logic [DAT_WIDTH/8-1:0] m1_sel_i,
  output logic [DAT_WIDTH-1:0]   m1_dat_o,
  output logic                   m1_ack_o,
  output logic                   m1_err_o,

  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [ADR_WIDTH-1:0]   s_adr_o,
  output logic [DAT_WIDTH-1:0]   s_dat_o,
  output logic [DAT_WIDTH/8-1:0] s_sel_o,
  input  logic [DAT_WIDTH-1:0]   s_dat_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,

  output logic [1:0]             gnt_o
);

  // A misconfigured stall limit is caught at elaboration rather than silently truncated.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
    $error("wb_arbiter: TIMEOUT_CYCLES must be within 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       last_gnt;      // 0: m0 was served last, 1: m1 was served last
  logic       last_gnt_nxt;
  logic [1:0] gnt;
  logic       to_err;        // forced error from the stall watchdog (0 when not built in)

  // State register: grant and round-robin history; reset makes m0 win the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Next-state: arbitrate only from IDLE or at release; a live CYC is never pre-empted.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = last_gnt ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_nxt = GNT0;
        end else if (m1_cyc_i) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_gnt_nxt = 1'b0;
          // Hand straight over when m1 is already waiting, saving the idle cycle.
          state_nxt    = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_gnt_nxt = 1'b1;
          state_nxt    = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request mux: the granted master drives the slave bus; with no grant the bus is all zeros.
  always_comb begin
    gnt     = 2'b00;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    case (state)
      GNT0: begin
        gnt     = 2'b01;
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
      end
      GNT1: begin
        gnt     = 2'b10;
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
      end
      default: ;
    endcase
  end

  assign gnt_o = gnt;

  // Response routing: terminations reach only the granted master; read data is broadcast.
  always_comb begin
    m0_ack_o = s_ack_i & gnt[0];
    m1_ack_o = s_ack_i & gnt[1];
    m0_err_o = (s_err_i | to_err) & gnt[0];
    m1_err_o = (s_err_i | to_err) & gnt[1];
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] to_cnt;
  logic        stall;
  logic        to_hit;

  // A stalled cycle is a granted, live strobe the slave has not terminated.
  assign stall  = s_cyc_o && s_stb_o && !s_ack_i && !s_err_i;
  assign to_hit = (to_cnt == TO_LIMIT);
  // A slave ACK landing in the timeout cycle wins; the transfer completes normally.
  assign to_err = to_hit && s_cyc_o && s_stb_o && !s_ack_i;

  // Stall watchdog: counts consecutive stalled cycles; restarts on any termination, idle strobe or grant change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt <= '0;
    end else if (to_hit || !stall || (state_nxt != state)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  assign to_err = 1'b0;
`endif

endmodule
